// File: rtl/ballot_pkg.sv
// ============================================================================
// Module      : ballot_pkg
// Description : Shared widths and state encoding for the ballot collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ballot_pkg;

    localparam int BALLOT_W = 5;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } ballot_state_e;

endpackage : ballot_pkg

`default_nettype wire

// File: rtl/ballot_idle_timer.sv
// ============================================================================
// Module      : ballot_idle_timer
// Description : Counts cycles without a kick while running; flags expiry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ballot_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int W = $clog2(TIMEOUT + 1);

            logic [W-1:0] r_cnt;
            logic         w_expire;

            // Expiry is the edge on which the counter would reach TIMEOUT.
            assign w_expire = run & ~kick & (r_cnt == W'(TIMEOUT - 1));
            assign expire   = w_expire;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!run || kick || w_expire) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + W'(1);
                end
            end
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, run, kick};
            assign expire   = 1'b0;
        end
    endgenerate

endmodule : ballot_idle_timer

`default_nettype wire

// File: rtl/ballot_collector.sv
// ============================================================================
// Module      : ballot_collector
// Description : Serialises five single-bit votes into a ballot vector a[4:0].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ballot_collector
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vote_valid,
    input  logic                vote,
    output logic                vote_ready,
    input  logic                clear,
    output logic [BALLOT_W-1:0] a,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [CNT_W-1:0]    yes_count,
    output logic                timeout
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_COLLECT = COLLECT;
    localparam logic [1:0] S_FULL    = FULL;

    logic [1:0]          r_state;
    logic [BALLOT_W-1:0] r_a;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_yes;
    logic                r_timeout;

    logic w_accept;
    logic w_expire;
    logic w_run;
    logic w_kick;

    assign vote_ready = (r_state != S_FULL);
    assign a_valid    = (r_state == S_FULL);
    assign a          = r_a;
    assign yes_count  = r_yes;
    assign timeout    = r_timeout;

    assign w_accept = vote_valid & vote_ready & ~clear;
    assign w_run    = (r_state == S_COLLECT);
    assign w_kick   = w_accept | clear;

    ballot_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_run),
        .kick   (w_kick),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_count   <= '0;
            r_yes     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_a     <= '0;
                r_count <= '0;
                r_yes   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_a     <= {r_a[BALLOT_W-2:0], vote};
                            r_count <= CNT_W'(1);
                            r_yes   <= {{(CNT_W-1){1'b0}}, vote};
                            r_state <= S_COLLECT;
                        end
                    end
                    S_COLLECT: begin
                        // An accepted vote outranks an expiring timer.
                        if (w_accept) begin
                            r_a     <= {r_a[BALLOT_W-2:0], vote};
                            r_count <= r_count + CNT_W'(1);
                            r_yes   <= r_yes + {{(CNT_W-1){1'b0}}, vote};
                            if (r_count == CNT_W'(BALLOT_W - 1)) begin
                                r_state <= S_FULL;
                            end
                        end else if (w_expire) begin
                            r_a       <= '0;
                            r_count   <= '0;
                            r_yes     <= '0;
                            r_timeout <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_FULL: begin
                        if (a_ready) begin
                            r_a     <= '0;
                            r_count <= '0;
                            r_yes   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_a     <= '0;
                        r_count <= '0;
                        r_yes   <= '0;
                    end
                endcase
            end
        end
    end

endmodule : ballot_collector

`default_nettype wire
